// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package md_pkg;

    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } mdop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_signed_op(input mdop_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input mdop_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the shift-add multiply or restoring divide on the {hi,lo} accumulator.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_fits;

    // NOTE: every output gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        acc_hi_o  = acc_hi_i;
        acc_lo_o  = acc_lo_i;
        mul_sum   = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : '0);
        div_shift = {acc_hi_i, acc_lo_i[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, opnd_i});
        // The true difference is below 2^WIDTH whenever it is kept, so the low bits suffice.
        div_diff  = div_shift[WIDTH-1:0] - opnd_i;

        if (is_div_i) begin
            acc_hi_o = div_fits ? div_diff : div_shift[WIDTH-1:0];
            acc_lo_o = {acc_lo_i[WIDTH-2:0], div_fits};
        end else begin
            acc_hi_o = mul_sum[WIDTH:1];
            acc_lo_o = {mul_sum[0], acc_lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/md_seq.sv
// Multiply/divide sequencer owning HI/LO: fixed WIDTH-cycle CALC schedule plus one FIX cycle.
module md_seq
    import md_pkg::*;
#(
    parameter int WIDTH = MD_ITERS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mdop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    mdop_e            op_q, op_d;
    logic             neg_q, neg_d;      // product / quotient sign
    logic             sa_q, sa_d;        // dividend sign, owned by the remainder
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    mdop_e              op_in;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_fix;

    assign op_in = mdop_e'(mdop);
    assign a_neg = is_signed_op(op_in) & a[WIDTH-1];
    assign b_neg = is_signed_op(op_in) & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_op(op_q)),
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .opnd_i   (opnd_q),
        .acc_hi_o (step_hi),
        .acc_lo_o (step_lo)
    );

    assign prod_fix = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        bzero_d  = bzero_q;
        a_d      = a_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
                if (start) begin
                    op_d     = op_in;
                    neg_d    = a_neg ^ b_neg;
                    sa_d     = a_neg;
                    bzero_d  = (b == '0);
                    a_d      = a;
                    acc_hi_d = '0;
                    // Multiply walks multiplier bits out of lo; divide walks dividend bits out of lo.
                    opnd_d   = is_div_op(op_in) ? b_mag : a_mag;
                    acc_lo_d = is_div_op(op_in) ? a_mag : b_mag;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (!is_div_op(op_q)) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (bzero_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = sa_q  ? -acc_hi_q : acc_hi_q;
                    lo_d = neg_q ? -acc_lo_q : acc_lo_q;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MULT;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            bzero_q  <= 1'b0;
            a_q      <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            bzero_q  <= bzero_d;
            a_q      <= a_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq: vector table for the four ops plus hand-written timing corner cases.
module tb_md_seq;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mdop;
    logic [31:0] a, b, wd;
    logic        hi_we, lo_we;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;

    md_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mdop  (mdop),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        string       name;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] eh, input logic [31:0] el, input string n);
        vec_t v;
        v.op = op; v.a = av; v.b = bv; v.exp_hi = eh; v.exp_lo = el; v.name = n;
        return v;
    endfunction

    // Start in cycle T; optionally MTHI alongside start, or a stray start+MTLO at T+5.
    task automatic run_op(input vec_t v, input bit hi_with_start, input bit inject);
        int busy_cnt;
        int done_cnt;
        @(negedge clk);
        start = 1'b1; mdop = v.op; a = v.a; b = v.b;
        if (hi_with_start) begin
            hi_we = 1'b1;
            wd    = 32'h1111_1111;
        end
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; a = 32'h0; b = 32'h0;
            if (inject && k == 5) begin
                start = 1'b1; mdop = MD_DIVU; a = 32'd100; b = 32'd7;
                lo_we = 1'b1; wd = 32'hDEAD_BEEF;
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (hi_with_start && k == 1) check({v.name, "_hi_direct"}, hi, 32'h1111_1111);
        end
        check({v.name, "_busy_cycles"}, busy_cnt, 33);
        check({v.name, "_done_early"}, done_cnt, 0);
        @(negedge clk);
        check({v.name, "_done"}, done, 1'b1);
        check({v.name, "_busy_end"}, busy, 1'b0);
        check({v.name, "_hi"}, hi, v.exp_hi);
        check({v.name, "_lo"}, lo, v.exp_lo);
    endtask

    initial begin
        int done_cnt;
        rst_n = 1'b0; start = 1'b0; mdop = 2'd0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;

        vecs[0]  = mk(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        vecs[1]  = mk(MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
        vecs[2]  = mk(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
        vecs[3]  = mk(MD_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, "divu_by0");
        vecs[4]  = mk(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_by_m1");
        vecs[5]  = mk(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7by_neg2");
        vecs[6]  = mk(MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100by7");
        vecs[7]  = mk(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min_sq");
        vecs[8]  = mk(MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg5_by0");
        vecs[9]  = mk(MD_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, "multu_shift");
        vecs[10] = mk(MD_MULT,  32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "mult_5x_m1");

        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst_n = 1'b1;

        @(negedge clk);
        hi_we = 1'b1; wd = 32'hAAAA_5555;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'hAAAA_5555);
        check("mthi_lo_kept", lo, 32'h0);
        lo_we = 1'b1; wd = 32'h0F0F_0F0F;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h0F0F_0F0F);
        check("mtlo_hi_kept", hi, 32'hAAAA_5555);

        for (int i = 0; i < 11; i++) run_op(vecs[i], 1'b0, 1'b0);

        run_op(mk(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "busy_ignore"), 1'b0, 1'b1);
        @(negedge clk);
        check("busy_ignore_no_second_done", done, 1'b0);
        check("busy_ignore_no_second_run", busy, 1'b0);

        run_op(mk(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "start_mthi"), 1'b1, 1'b0);

        @(negedge clk);
        start = 1'b1; mdop = MD_MULT; a = 32'hFFFF_FFFD; b = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrun_busy_before_reset", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 1'b0);

        run_op(mk(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "after_reset"), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
